// File: rtl/monobit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | monobit_pkg: shared types, defaults and width helper for the monobit |
// | window controller.                     Rev 1.0                       |
// +----------------------------------------------------------------------+
package monobit_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      EVAL    = 2'd2,
      HOLD    = 2'd3
   } state_t;

   localparam int DEF_N_BITS = 128;
   // floor(2.5758*sqrt(128)): alpha = 0.01 bound for a 128-bit window
   localparam int DEF_THRESH = 29;

   function automatic int cnt_width(input int n);
      return $clog2(n + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/monobit_window_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | monobit_window_ctrl_if: bit-stream and result handshake bundle.      |
// |                                        Rev 1.0                       |
// +----------------------------------------------------------------------+
interface monobit_window_ctrl_if
   import monobit_pkg::*;
#(
   parameter int N_BITS = DEF_N_BITS
);
   localparam int CW = cnt_width(N_BITS);

   logic          bit_in;
   logic          bit_valid;
   logic          bit_ready;
   logic          res_valid;
   logic          res_ready;
   logic          res_pass;
   logic [CW:0]   res_sum;
   logic [CW-1:0] res_ones;
   logic [7:0]    res_win_id;

   // master: bit source / result consumer; slave: the controller
   modport master (
      output bit_in, bit_valid, res_ready,
      input  bit_ready, res_valid, res_pass, res_sum, res_ones, res_win_id
   );

   modport slave (
      input  bit_in, bit_valid, res_ready,
      output bit_ready, res_valid, res_pass, res_sum, res_ones, res_win_id
   );

endinterface
`default_nettype wire

// File: rtl/monobit_accum.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | monobit_accum: per-window bit counter and ones counter.              |
// |                                        Rev 1.0                       |
// +----------------------------------------------------------------------+
module monobit_accum
   import monobit_pkg::*;
#(
   parameter int N_BITS = DEF_N_BITS,
   localparam int CW    = cnt_width(N_BITS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          en,
   input  logic          bit_in,
   output logic [CW-1:0] ones,
   output logic          last
);
   localparam logic [CW-1:0] N_V = CW'(N_BITS);

   logic [CW-1:0] bit_cnt;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         bit_cnt <= '0;
         ones    <= '0;
      end else if (en) begin
         bit_cnt <= bit_cnt + CW'(1);
         ones    <= ones + CW'(bit_in);
      end
   end

   // High in the cycle right after the final bit of the window was taken
   assign last = (bit_cnt == N_V);

endmodule
`default_nettype wire

// File: rtl/monobit_window_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | monobit_window_ctrl: cuts a bit stream into windows and issues a     |
// | monobit pass/fail result per window.   Rev 1.0                       |
// +----------------------------------------------------------------------+
module monobit_window_ctrl
   import monobit_pkg::*;
#(
   parameter int N_BITS = DEF_N_BITS,
   parameter int THRESH = DEF_THRESH
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic cont,
   input  logic abort,
   output logic busy,
   monobit_window_ctrl_if.slave bus
);
   localparam int CW = cnt_width(N_BITS);
   localparam logic [CW:0] NB_V = (CW+1)'(N_BITS);
   localparam logic [CW:0] TH_V = (CW+1)'(THRESH);

   state_t        state;
   state_t        state_nx;
   logic          bit_ready;
   logic          cont_lat;
   logic          last;
   logic          acc_en;
   logic          acc_clr;
   logic          hs;
   logic [CW-1:0] ones;
   logic [CW:0]   sum_s;
   logic [CW:0]   abs_s;
   logic          pass_s;
   logic          res_pass;
   logic [CW:0]   res_sum;
   logic [CW-1:0] res_ones;
   logic [7:0]    res_win_id;

   assign hs      = (state == HOLD) && bus.res_ready;
   assign acc_clr = abort || hs;
   assign acc_en  = bus.bit_valid && bit_ready;

   monobit_accum #(
      .N_BITS (N_BITS)
   ) u_accum (
      .clk    (clk),
      .rst    (rst),
      .clr    (acc_clr),
      .en     (acc_en),
      .bit_in (bus.bit_in),
      .ones   (ones),
      .last   (last)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      bit_ready = 1'b0;
      case (state)
         IDLE:    if (start) state_nx = COLLECT;
         COLLECT: begin
            bit_ready = !last;
            if (last) state_nx = EVAL;
         end
         EVAL:    state_nx = HOLD;
         HOLD:    if (bus.res_ready) state_nx = cont_lat ? COLLECT : IDLE;
         default: state_nx = IDLE;
      endcase
      if (abort) begin
         state_nx  = IDLE;
         bit_ready = 1'b0;
      end
   end

   // S = 2*ones - N in CW+1 bits; wraps modulo 2^(CW+1) into the exact value
   assign sum_s  = {ones, 1'b0} - NB_V;
   assign abs_s  = sum_s[CW] ? (~sum_s + (CW+1)'(1)) : sum_s;
   assign pass_s = (abs_s <= TH_V);

   always_ff @(posedge clk) begin
      if (rst) begin
         cont_lat   <= 1'b0;
         res_pass   <= 1'b0;
         res_sum    <= '0;
         res_ones   <= '0;
         res_win_id <= 8'd0;
      end else if (abort) begin
         cont_lat <= 1'b0;
         res_pass <= 1'b0;
         res_sum  <= '0;
         res_ones <= '0;
      end else begin
         if (state == IDLE && start) cont_lat <= cont;
         if (state == EVAL) begin
            res_pass <= pass_s;
            res_sum  <= sum_s;
            res_ones <= ones;
         end
         if (hs) begin
            res_win_id <= res_win_id + 8'd1;
            if (cont_lat) cont_lat <= cont;
         end
      end
   end

   assign busy           = (state != IDLE);
   assign bus.bit_ready  = bit_ready;
   assign bus.res_valid  = (state == HOLD);
   assign bus.res_pass   = res_pass;
   assign bus.res_sum    = res_sum;
   assign bus.res_ones   = res_ones;
   assign bus.res_win_id = res_win_id;

endmodule
`default_nettype wire
